// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-granular memory-to-memory copy engine.
// Acts as a bus initiator on the req/gnt/rvalid data bus and copies `len`
// words from src to dst, one read followed by one write per word, with at
// most one outstanding transaction. Completion or bus error is reported
// through sticky done/err flags and a one-cycle irq pulse.
module dma_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  output logic [LEN_W-1:0] words_done,
  output logic             data_req,
  output logic             data_we,
  output logic [3:0]       data_be,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_gnt,
  input  logic             data_rvalid,
  input  logic [31:0]      data_rdata,
  input  logic             data_err
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      hold_q;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] words_q;
  logic             done_q;
  logic             err_q;

  // State register; reset drops any in-flight request on the next edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus/status decode, all outputs derived from registered state only.
  always_comb begin
    state_next = state;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = src_q;
    busy       = 1'b0;
    irq        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        busy     = 1'b1;
        data_req = 1'b1;
        if (data_gnt) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (data_rvalid) begin
          state_next = data_err ? FINISH : WR_REQ;
        end
      end
      WR_REQ: begin
        busy      = 1'b1;
        data_req  = 1'b1;
        data_we   = 1'b1;
        data_addr = dst_q;
        if (data_gnt) begin
          state_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        busy      = 1'b1;
        data_addr = dst_q;
        if (data_rvalid) begin
          if (data_err || (remaining_q == LEN_W'(1))) begin
            state_next = FINISH;
          end else begin
            state_next = RD_REQ;
          end
        end
      end
      FINISH: begin
        irq        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Working registers: command latch, read holding register, progress counters and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q       <= '0;
      dst_q       <= '0;
      hold_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q       <= src_addr & ~32'd3;
            dst_q       <= dst_addr & ~32'd3;
            remaining_q <= len;
            words_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= (len == '0);
          end
        end
        RD_WAIT: begin
          if (data_rvalid) begin
            if (data_err) begin
              err_q <= 1'b1;
            end else begin
              hold_q <= data_rdata;
            end
          end
        end
        WR_WAIT: begin
          if (data_rvalid) begin
            if (data_err) begin
              err_q <= 1'b1;
            end else begin
              words_q     <= words_q + LEN_W'(1);
              src_q       <= src_q + 32'd4;
              dst_q       <= dst_q + 32'd4;
              remaining_q <= remaining_q - LEN_W'(1);
              if (remaining_q == LEN_W'(1)) begin
                done_q <= 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;
  assign data_be    = 4'hF;
  assign data_wdata = hold_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: table-driven and randomized checks of the copy engine
// against a transaction-level model of the copy (expected bus trace, final
// flags, word count and irq timing derived from the operation rules).
module tb_dma_copy_engine;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy, done, err, irq;
  logic [LEN_W-1:0] words_done;
  logic             data_req, data_we;
  logic [3:0]       data_be;
  logic [31:0]      data_addr, data_wdata;
  logic             data_gnt, data_rvalid, data_err;
  logic [31:0]      data_rdata;

  always #5 clk = ~clk;

  dma_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .irq         (irq),
    .words_done  (words_done),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .data_err    (data_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    int               gnt;
    int               rv;
    int               err_txn;
    int               busy_start_at;
    logic             exp_done;
    logic             exp_err;
    logic [LEN_W-1:0] exp_words;
    int               exp_irq;
  } vec_t;

  txn_t log_q[$];
  txn_t exp_q[$];
  logic [31:0] pre [logic [31:0]];

  int cfg_gnt_dly = 0;
  int cfg_rv_dly  = 0;
  int cfg_err_abs = -1;
  bit resp_clear  = 1'b1;
  int viol_cnt    = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory contents seen by the responder: preloaded words or an address hash.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (pre.exists(a)) return pre[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Responder: configurable gnt/rvalid latency, error injection, protocol checks.
  initial begin : responder
    bit          pend;
    bit          pend_err;
    int          rv_cnt;
    int          wait_cnt;
    logic [31:0] pend_data;
    txn_t        held;
    pend = 1'b0; pend_err = 1'b0; rv_cnt = 0; wait_cnt = 0; pend_data = '0;
    held = '{1'b0, 32'h0, 32'h0};
    data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0;
    forever begin
      @(negedge clk);
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      data_err    = 1'b0;
      data_rdata  = $urandom;
      if (resp_clear) begin
        pend     = 1'b0;
        wait_cnt = 0;
      end else if (pend) begin
        if (data_req) viol_cnt++;
        if (rv_cnt == 0) begin
          data_rvalid = 1'b1;
          data_err    = pend_err;
          data_rdata  = pend_data;
          pend        = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (data_req) begin
        if (data_be != 4'hF) viol_cnt++;
        if (wait_cnt > 0 && (data_we != held.we || data_addr != held.addr ||
                             data_wdata != held.wdata)) viol_cnt++;
        held = '{data_we, data_addr, data_wdata};
        if (wait_cnt < cfg_gnt_dly) begin
          wait_cnt++;
        end else begin
          data_gnt  = 1'b1;
          wait_cnt  = 0;
          pend_err  = (log_q.size() == cfg_err_abs);
          pend_data = data_we ? $urandom : mem_rd(data_addr);
          log_q.push_back(held);
          pend      = 1'b1;
          rv_cnt    = cfg_rv_dly;
        end
      end
    end
  end

  // Expected bus trace: read src+4i then write dst+4i, stopping at the failing transaction.
  function automatic void build_model(input vec_t v);
    logic [31:0] s;
    logic [31:0] d;
    s = v.src & ~32'd3;
    d = v.dst & ~32'd3;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      exp_q.push_back('{1'b0, s, 32'h0});
      if (v.err_txn == 2 * i) return;
      exp_q.push_back('{1'b1, d, mem_rd(s)});
      if (v.err_txn == 2 * i + 1) return;
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endfunction

  // Expected final status and irq cycle for a randomized command.
  function automatic vec_t fill_expect(input vec_t v);
    vec_t r;
    int   ntx;
    bit   erred;
    r = v;
    build_model(v);
    ntx   = exp_q.size();
    erred = (v.err_txn >= 0) && (v.err_txn < 2 * int'(v.len));
    r.exp_done  = !erred;
    r.exp_err   = erred;
    r.exp_words = erred ? LEN_W'(v.err_txn / 2) : v.len;
    r.exp_irq   = (v.len == '0) ? 1 : 1 + ntx * (v.gnt + v.rv + 2);
    r.busy_start_at = (r.exp_irq > 3) ? int'($urandom_range(2, r.exp_irq - 1)) : 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int k;
    int irq_first;
    int irq_cnt;
    int base;
    int vbase;
    bit req_seen;
    build_model(v);
    base  = log_q.size();
    vbase = viol_cnt;
    cfg_gnt_dly = v.gnt;
    cfg_rv_dly  = v.rv;
    cfg_err_abs = (v.err_txn < 0) ? -1 : base + v.err_txn;
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
    k = 1; irq_first = -1; irq_cnt = 0; req_seen = 1'b0;
    checkOutput({tag, " req@T+1"}, 32'(data_req), 32'(v.len != '0));
    checkOutput({tag, " busy@T+1"}, 32'(busy), 32'(v.len != '0));
    while (k < 3000) begin
      start = (k == v.busy_start_at);
      if (data_req) req_seen = 1'b1;
      if (irq) begin
        irq_cnt++;
        if (irq_first < 0) begin
          irq_first = k;
          checkOutput({tag, " busy@irq"}, 32'(busy), 32'h0);
          checkOutput({tag, " done@irq"}, 32'(done), 32'(v.exp_done));
          checkOutput({tag, " err@irq"}, 32'(err), 32'(v.exp_err));
        end
      end
      if (irq_first >= 0 && k >= irq_first + 3) break;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checkOutput({tag, " irq cycle"}, irq_first, v.exp_irq);
    checkOutput({tag, " irq pulses"}, irq_cnt, 1);
    checkOutput({tag, " done"}, 32'(done), 32'(v.exp_done));
    checkOutput({tag, " err"}, 32'(err), 32'(v.exp_err));
    checkOutput({tag, " words_done"}, 32'(words_done), 32'(v.exp_words));
    checkOutput({tag, " any req"}, 32'(req_seen), 32'(v.len != '0));
    checkOutput({tag, " txn count"}, log_q.size() - base, exp_q.size());
    checkOutput({tag, " protocol"}, viol_cnt - vbase, 0);
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      checkOutput($sformatf("%s txn%0d we", tag, i), 32'(log_q[base + i].we), 32'(exp_q[i].we));
      checkOutput($sformatf("%s txn%0d addr", tag, i), log_q[base + i].addr, exp_q[i].addr);
      if (exp_q[i].we)
        checkOutput($sformatf("%s txn%0d wdata", tag, i), log_q[base + i].wdata, exp_q[i].wdata);
    end
  endtask

  // Main sequence: reset, fixed table, mid-transfer reset, randomized commands.
  initial begin : main
    vec_t vecs[7];
    vec_t r;
    int   base;
    rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    pre[32'h1000] = 32'hA; pre[32'h1004] = 32'hB; pre[32'h1008] = 32'hC;

    vecs[0] = '{32'h0000_1000, 32'h0000_2000, 16'd3, 0, 0, -1, 0, 1'b1, 1'b0, 16'd3, 13};
    vecs[1] = '{32'h0000_1000, 32'h0000_3000, 16'd3, 3, 2, -1, 0, 1'b1, 1'b0, 16'd3, 43};
    vecs[2] = '{32'h0000_1234, 32'h0000_5678, 16'd0, 0, 0, -1, 0, 1'b1, 1'b0, 16'd0, 1};
    vecs[3] = '{32'h0000_4000, 32'h0000_5000, 16'd4, 0, 0,  2, 0, 1'b0, 1'b1, 16'd1, 7};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0100, 16'd2, 0, 0, -1, 3, 1'b1, 1'b0, 16'd2, 9};
    vecs[5] = '{32'h0000_8000, 32'h0000_9000, 16'd2, 0, 0,  1, 0, 1'b0, 1'b1, 16'd0, 5};
    vecs[6] = '{32'h0000_1003, 32'h0000_2002, 16'd1, 1, 1, -1, 0, 1'b1, 1'b0, 16'd1, 9};

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    checkOutput("reset irq", 32'(irq), 32'h0);
    checkOutput("reset words_done", 32'(words_done), 32'h0);
    checkOutput("reset data_req", 32'(data_req), 32'h0);
    checkOutput("reset data_we", 32'(data_we), 32'h0);
    checkOutput("reset data_be", 32'(data_be), 32'hF);
    checkOutput("reset data_addr", data_addr, 32'h0);
    checkOutput("reset data_wdata", data_wdata, 32'h0);
    rst = 1'b1;
    resp_clear = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while the first write response is being returned.
    base = log_q.size();
    cfg_gnt_dly = 0; cfg_rv_dly = 0; cfg_err_abs = -1;
    @(negedge clk);
    src_addr = 32'h0000_6000; dst_addr = 32'h0000_7000; len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst-mid busy in WR_WAIT", 32'(busy), 32'h1);
    checkOutput("rst-mid txns before reset", log_q.size() - base, 2);
    rst = 1'b0;
    resp_clear = 1'b1;
    @(negedge clk);
    checkOutput("rst-mid busy", 32'(busy), 32'h0);
    checkOutput("rst-mid done", 32'(done), 32'h0);
    checkOutput("rst-mid err", 32'(err), 32'h0);
    checkOutput("rst-mid irq", 32'(irq), 32'h0);
    checkOutput("rst-mid words_done", 32'(words_done), 32'h0);
    checkOutput("rst-mid data_req", 32'(data_req), 32'h0);
    checkOutput("rst-mid data_we", 32'(data_we), 32'h0);
    checkOutput("rst-mid data_be", 32'(data_be), 32'hF);
    checkOutput("rst-mid data_addr", data_addr, 32'h0);
    checkOutput("rst-mid data_wdata", data_wdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    resp_clear = 1'b0;
    applyStimulus(vecs[0], "post-reset");

    for (int n = 0; n < 16; n++) begin
      r.src = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      r.dst = $urandom;
      r.len = LEN_W'($urandom_range(0, 5));
      r.gnt = int'($urandom_range(0, 3));
      r.rv  = int'($urandom_range(0, 3));
      r.err_txn = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 11));
      r.busy_start_at = 0;
      r.exp_done = 1'b0; r.exp_err = 1'b0; r.exp_words = '0; r.exp_irq = 0;
      r = fill_expect(r);
      applyStimulus(r, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
